// File: rtl/ht_bcd_sched.sv
// Two-requester scheduler around one shift-add-3 binary-to-BCD engine for temperature and humidity display words.
// Latency: grant to valid is 19 cycles. Requests are never back-pressured: a repeat request overwrites the pending code.
module ht_bcd_sched #(
    parameter int unsigned T_SCALE  = 17500,
    parameter int unsigned T_OFFSET = 4500,
    parameter int unsigned H_SCALE  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        t_req,
    input  logic [15:0] t_code,
    input  logic        h_req,
    input  logic [15:0] h_code,
    output logic        busy,
    output logic        t_valid,
    output logic [15:0] t_disp,
    output logic        t_neg,
    output logic        h_valid,
    output logic [15:0] h_disp,
    output logic [7:0]  dat_en,
    output logic [7:0]  dot_en
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCALE = 2'd1,
        S_CONV  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] T_SCALE_W = 32'(T_SCALE);
    localparam logic [31:0] H_SCALE_W = 32'(H_SCALE);
    localparam logic [15:0] T_OFF_W   = 16'(T_OFFSET);

    state_t state_q, state_d;

    logic        t_pend_q, t_pend_d;
    logic        h_pend_q, h_pend_d;
    logic [15:0] t_code_q, t_code_d;
    logic [15:0] h_code_q, h_code_d;
    logic        last_t_q, last_t_d;
    logic        sel_t_q, sel_t_d;
    logic [15:0] work_q, work_d;
    logic        neg_q, neg_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        t_valid_q, t_valid_d;
    logic        h_valid_q, h_valid_d;
    logic [15:0] t_disp_q, t_disp_d;
    logic        t_neg_q, t_neg_d;
    logic [15:0] h_disp_q, h_disp_d;
    logic [7:0]  dat_en_q, dat_en_d;
    logic [7:0]  dot_en_q, dot_en_d;

    logic        grant_t, grant_h;
    logic        in_scale, in_conv, in_done;
    logic [15:0] t_b, t_mag, h_mag;
    logic        t_below;
    logic [19:0] bcd_adj;
    logic [15:0] t_disp_n, h_disp_n;

    function automatic logic [19:0] add3(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int i = 0; i < 5; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_t || grant_h) state_d = S_SCALE;
            S_SCALE: state_d = S_CONV;
            S_CONV:  if (cnt_q == 4'd15) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / control decode; when both are pending the path not served last wins
    always_comb begin
        busy     = (state_q != S_IDLE);
        grant_t  = (state_q == S_IDLE) && t_pend_q && (!h_pend_q || !last_t_q);
        grant_h  = (state_q == S_IDLE) && h_pend_q && (!t_pend_q || last_t_q);
        in_scale = (state_q == S_SCALE);
        in_conv  = (state_q == S_CONV);
        in_done  = (state_q == S_DONE);
    end

    always_comb begin
        t_b      = 16'((32'(work_q) * T_SCALE_W) >> 16);
        h_mag    = 16'((32'(work_q) * H_SCALE_W) >> 16);
        t_below  = (t_b < T_OFF_W);
        t_mag    = t_below ? (T_OFF_W - t_b) : (t_b - T_OFF_W);
        bcd_adj  = add3(bcd_q);
        t_disp_n = neg_q ? {4'hA, bcd_q[15:4]} : bcd_q[19:4];
        h_disp_n = bcd_q[15:0];
    end

    always_comb begin
        t_pend_d  = t_pend_q;
        h_pend_d  = h_pend_q;
        t_code_d  = t_code_q;
        h_code_d  = h_code_q;
        last_t_d  = last_t_q;
        sel_t_d   = sel_t_q;
        work_d    = work_q;
        neg_d     = neg_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        t_valid_d = 1'b0;
        h_valid_d = 1'b0;
        t_disp_d  = t_disp_q;
        t_neg_d   = t_neg_q;
        h_disp_d  = h_disp_q;
        dat_en_d  = dat_en_q;
        dot_en_d  = dot_en_q;

        // Grant copies the latch as it was before this edge; a coincident request re-arms the flag
        if (grant_t) begin
            t_pend_d = 1'b0;
            work_d   = t_code_q;
            last_t_d = 1'b1;
            sel_t_d  = 1'b1;
        end
        if (grant_h) begin
            h_pend_d = 1'b0;
            work_d   = h_code_q;
            last_t_d = 1'b0;
            sel_t_d  = 1'b0;
        end
        if (t_req) begin
            t_pend_d = 1'b1;
            t_code_d = t_code;
        end
        if (h_req) begin
            h_pend_d = 1'b1;
            h_code_d = h_code;
        end

        if (in_scale) begin
            neg_d = sel_t_q ? t_below : 1'b0;
            bin_d = sel_t_q ? t_mag : h_mag;
            bcd_d = 20'd0;
            cnt_d = 4'd0;
        end

        if (in_conv) begin
            bcd_d = {bcd_adj[18:0], bin_q[15]};
            bin_d = {bin_q[14:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
        end

        if (in_done) begin
            if (sel_t_q) begin
                t_valid_d     = 1'b1;
                t_disp_d      = t_disp_n;
                t_neg_d       = neg_q;
                dat_en_d[7]   = |t_disp_n[15:12];
                dat_en_d[6]   = neg_q ? |t_disp_n[11:8] : |t_disp_n[15:8];
                dat_en_d[5:4] = 2'b11;
                dot_en_d[7:4] = 4'b0010;
            end else begin
                h_valid_d     = 1'b1;
                h_disp_d      = h_disp_n;
                dat_en_d[3]   = |h_disp_n[15:12];
                dat_en_d[2]   = |h_disp_n[15:8];
                dat_en_d[1:0] = 2'b11;
                dot_en_d[3:0] = 4'b0010;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_pend_q  <= 1'b0;
            h_pend_q  <= 1'b0;
            t_code_q  <= 16'd0;
            h_code_q  <= 16'd0;
            last_t_q  <= 1'b0;
            sel_t_q   <= 1'b0;
            work_q    <= 16'd0;
            neg_q     <= 1'b0;
            bin_q     <= 16'd0;
            bcd_q     <= 20'd0;
            cnt_q     <= 4'd0;
            t_valid_q <= 1'b0;
            h_valid_q <= 1'b0;
            t_disp_q  <= 16'd0;
            t_neg_q   <= 1'b0;
            h_disp_q  <= 16'd0;
            dat_en_q  <= 8'd0;
            dot_en_q  <= 8'd0;
        end else begin
            t_pend_q  <= t_pend_d;
            h_pend_q  <= h_pend_d;
            t_code_q  <= t_code_d;
            h_code_q  <= h_code_d;
            last_t_q  <= last_t_d;
            sel_t_q   <= sel_t_d;
            work_q    <= work_d;
            neg_q     <= neg_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            t_valid_q <= t_valid_d;
            h_valid_q <= h_valid_d;
            t_disp_q  <= t_disp_d;
            t_neg_q   <= t_neg_d;
            h_disp_q  <= h_disp_d;
            dat_en_q  <= dat_en_d;
            dot_en_q  <= dot_en_d;
        end
    end

    assign t_valid = t_valid_q;
    assign h_valid = h_valid_q;
    assign t_disp  = t_disp_q;
    assign t_neg   = t_neg_q;
    assign h_disp  = h_disp_q;
    assign dat_en  = dat_en_q;
    assign dot_en  = dot_en_q;

endmodule

// File: tb/tb_ht_bcd_sched.sv
// Directed bench for ht_bcd_sched: vector table of single conversions plus arbitration, overwrite and reset sequences.
module tb_ht_bcd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        t_req, h_req;
    logic [15:0] t_code, h_code;
    logic        busy, t_valid, h_valid, t_neg;
    logic [15:0] t_disp, h_disp;
    logic [7:0]  dat_en, dot_en;

    ht_bcd_sched dut (
        .clk    (clk),
        .rst    (rst),
        .t_req  (t_req),
        .t_code (t_code),
        .h_req  (h_req),
        .h_code (h_code),
        .busy   (busy),
        .t_valid(t_valid),
        .t_disp (t_disp),
        .t_neg  (t_neg),
        .h_valid(h_valid),
        .h_disp (h_disp),
        .dat_en (dat_en),
        .dot_en (dot_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] en_m, dot_m;

    typedef struct packed {
        logic        is_t;
        logic [15:0] code;
        logic [15:0] disp;
        logic        neg;
        logic [3:0]  en;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive a one-cycle request in cycle 'at' (0 = next negedge); 'when' returns its cycle number.
    task automatic drive(input int at, input bit tr, input bit hr,
                         input logic [15:0] tc, input logic [15:0] hc, output int when);
        if (at == 0) @(negedge clk);
        else while (cyc < at) @(negedge clk);
        t_req = tr;
        h_req = hr;
        if (tr) t_code = tc;
        if (hr) h_code = hc;
        when = cyc;
        @(negedge clk);
        t_req = 1'b0;
        h_req = 1'b0;
    endtask

    task automatic wait_ev(input int start, output int rel, output bit got_t);
        rel   = -1;
        got_t = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (t_valid || h_valid) begin
                chk("valid_exclusive", 32'(t_valid & h_valid), 32'd0);
                rel   = cyc - start;
                got_t = t_valid;
                break;
            end
        end
    endtask

    task automatic expect_out(input string nm, input int start, input int exp_rel, input bit is_t,
                              input logic [15:0] disp, input bit neg, input logic [3:0] en);
        int rel;
        bit got_t;
        wait_ev(start, rel, got_t);
        chk({nm, "_lat"}, 32'(rel), 32'(exp_rel));
        chk({nm, "_path"}, 32'(got_t), 32'(is_t));
        if (is_t) begin
            en_m[7:4]  = en;
            dot_m[7:4] = 4'b0010;
            chk({nm, "_t_disp"}, 32'(t_disp), 32'(disp));
            chk({nm, "_t_neg"}, 32'(t_neg), 32'(neg));
        end else begin
            en_m[3:0]  = en;
            dot_m[3:0] = 4'b0010;
            chk({nm, "_h_disp"}, 32'(h_disp), 32'(disp));
        end
        chk({nm, "_dat_en"}, 32'(dat_en), 32'(en_m));
        chk({nm, "_dot_en"}, 32'(dot_en), 32'(dot_m));
        @(posedge clk);
        #1;
        chk({nm, "_pulse"}, 32'({t_valid, h_valid}), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en_m  = 8'd0;
        dot_m = 8'd0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int s, vcnt;
        vt[0] = '{1'b1, 16'h0000, 16'hA450, 1'b1, 4'b1111};
        vt[1] = '{1'b1, 16'hFFFF, 16'h1299, 1'b0, 4'b1111};
        vt[2] = '{1'b1, 16'h6000, 16'h0206, 1'b0, 4'b0111};
        vt[3] = '{1'b1, 16'd16853, 16'h0000, 1'b0, 4'b0011};
        vt[4] = '{1'b1, 16'h2000, 16'hA231, 1'b1, 4'b1111};
        vt[5] = '{1'b1, 16'd16480, 16'hA010, 1'b1, 4'b1011};
        vt[6] = '{1'b0, 16'hFFFF, 16'h0999, 1'b0, 4'b0111};
        vt[7] = '{1'b0, 16'h8000, 16'h0500, 1'b0, 4'b0111};
        vt[8] = '{1'b0, 16'h1999, 16'h0099, 1'b0, 4'b0011};
        vt[9] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 4'b0011};

        rst = 1'b1; t_req = 1'b0; h_req = 1'b0; t_code = 16'd0; h_code = 16'd0;
        en_m = 8'd0; dot_m = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_t_valid", 32'(t_valid), 32'd0);
        chk("rst_h_valid", 32'(h_valid), 32'd0);
        chk("rst_t_disp", 32'(t_disp), 32'd0);
        chk("rst_t_neg", 32'(t_neg), 32'd0);
        chk("rst_h_disp", 32'(h_disp), 32'd0);
        chk("rst_dat_en", 32'(dat_en), 32'd0);
        chk("rst_dot_en", 32'(dot_en), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(0, vt[i].is_t, !vt[i].is_t, vt[i].code, vt[i].code, s);
            chk("busy_after_req", 32'(busy), 32'd0);
            expect_out($sformatf("vec%0d", i), s, 20, vt[i].is_t, vt[i].disp, vt[i].neg, vt[i].en);
        end

        // Simultaneous requests: T first after reset, then T again since H was served last
        do_reset();
        drive(0, 1'b1, 1'b1, 16'h6000, 16'hFFFF, s);
        expect_out("both1_t", s, 20, 1'b1, 16'h0206, 1'b0, 4'b0111);
        expect_out("both1_h", s, 39, 1'b0, 16'h0999, 1'b0, 4'b0111);
        drive(0, 1'b1, 1'b1, 16'hFFFF, 16'h8000, s);
        expect_out("both2_t", s, 20, 1'b1, 16'h1299, 1'b0, 4'b1111);
        expect_out("both2_h", s, 39, 1'b0, 16'h0500, 1'b0, 4'b0111);
        // T served last, so H wins the next tie
        drive(0, 1'b1, 1'b0, 16'h0000, 16'h0000, s);
        expect_out("t_alone", s, 20, 1'b1, 16'hA450, 1'b1, 4'b1111);
        drive(0, 1'b1, 1'b1, 16'd16853, 16'h1999, s);
        expect_out("both3_h", s, 20, 1'b0, 16'h0099, 1'b0, 4'b0011);
        expect_out("both3_t", s, 39, 1'b1, 16'h0000, 1'b0, 4'b0011);

        // Re-request while busy: the newest code is converted next
        drive(0, 1'b1, 1'b0, 16'h2000, 16'h0000, s);
        drive(s + 5, 1'b1, 1'b0, 16'd16480, 16'h0000, vcnt);
        expect_out("busy_req_a", s, 20, 1'b1, 16'hA231, 1'b1, 4'b1111);
        expect_out("busy_req_b", s, 39, 1'b1, 16'hA010, 1'b1, 4'b1011);

        // Request on its own grant edge survives
        drive(0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, s);
        drive(s + 1, 1'b1, 1'b0, 16'h6000, 16'h0000, vcnt);
        expect_out("grant_edge_a", s, 20, 1'b1, 16'h1299, 1'b0, 4'b1111);
        expect_out("grant_edge_b", s, 39, 1'b1, 16'h0206, 1'b0, 4'b0111);

        // Reset in the middle of a conversion with another job pending
        drive(0, 1'b1, 1'b1, 16'h0000, 16'h8000, s);
        while (cyc < s + 10) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en_m  = 8'd0;
        dot_m = 8'd0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_t_disp", 32'(t_disp), 32'd0);
        chk("mid_rst_t_neg", 32'(t_neg), 32'd0);
        chk("mid_rst_h_disp", 32'(h_disp), 32'd0);
        chk("mid_rst_dat_en", 32'(dat_en), 32'd0);
        chk("mid_rst_dot_en", 32'(dot_en), 32'd0);
        chk("mid_rst_valid", 32'({t_valid, h_valid}), 32'd0);
        vcnt = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (t_valid || h_valid || busy) vcnt++;
        end
        chk("mid_rst_quiet", 32'(vcnt), 32'd0);
        drive(0, 1'b0, 1'b1, 16'h0000, 16'h8000, s);
        expect_out("post_rst_h", s, 20, 1'b0, 16'h0500, 1'b0, 4'b0111);
        drive(0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, s);
        expect_out("post_rst_t", s, 20, 1'b1, 16'h1299, 1'b0, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
